fetch_ctl_ras: RTL and testbench
================================

// Module: fetch_ctl_ras
// PURPOSE
//  Next-gen instruction-fetch program counter. Parametrised PC width and halt address.
//  Adds stall, absolute/PC-relative conditional branches, call/return through a return-address
//  stack (RAS), a sticky halt state and restart. Drives instruction ROM address; sits ahead of decode.
// PARAMETERS
//  PC_W      10   PC / Target width in bits
//  HALT_ADDR 8    PC value whose retirement enters HALTED
//  RAS_DEPTH 4    return-address stack entries (>=2, power of 2)
//  REL_EN    1    1: Br_rel honoured; 0: all branches absolute, Br_rel ignored
// PORTS
//  CLK          in  1     clock, all state changes on posedge
//  Init         in  1     reset, asynchronous, active-high
//  Stall        in  1     hold PC/state/RAS this cycle (RUN only)
//  Start        in  1     restart pulse, used in HALTED only
//  Branch_en    in  1     conditional branch request
//  FLAG_IN      in  1     branch condition; taken = Branch_en & FLAG_IN
//  Br_rel       in  1     1: target = PC + signed Target; 0: target = Target
//  Target       in  PC_W  branch/call target (two's complement when relative)
//  Call_en      in  1     call: push PC+1, jump to Target (always absolute)
//  Ret_en       in  1     return: pop RAS into PC
//  PC           out PC_W  program counter
//  Halt         out 1     1 while in HALTED
//  Ras_ovf      out 1     sticky: push while RAS full
//  Ras_unf      out 1     sticky: pop while RAS empty
// BEHAVIOUR
//  Reset (Init=1, any time, async):
//   - PC=0, Halt=0, Ras_ovf=0, Ras_unf=0, RAS count=0, state=RUN.
//   - Mid-operation reset discards pending call/ret.
//  States: RUN, HALTED. Halt = (state==HALTED), registered.
//  RUN, Stall=1: nothing changes; all requests that cycle ignored.
//  RUN, Stall=0, one action per cycle in priority order:
//   1 Ret_en:
//     - count>0: PC<=top, count-1.
//     - count==0: PC<=PC+1, Ras_unf<=1.
//   2 Call_en: PC<=Target, push PC+1.
//     - count==RAS_DEPTH: oldest entry overwritten (circular), count stays, Ras_ovf<=1.
//   3 taken branch: PC<=Br_rel&&REL_EN ? PC+Target : Target.
//   4 PC==HALT_ADDR: PC<=PC+1, state<=HALTED.
//   5 else PC<=PC+1.
//  Branch_en with FLAG_IN=0 is not taken and falls to rules 4/5.
//  Lower-priority requests in the same cycle are dropped, not queued.
//  Jump/call/ret taken at PC==HALT_ADDR: no halt.
//  Arithmetic: all PC math modulo 2^PC_W; PC=2^PC_W-1 wraps to 0.
//   - Relative Target sign-extended to PC_W (already PC_W wide).
//   - Relative offset is from the current PC, not PC+1.
//  HALTED:
//   - PC, RAS, flags frozen; Stall, branch, call, ret ignored.
//   - Start=1: PC<=0, state<=RUN, Halt<=0; RAS and sticky flags kept.
//  Latency: every change visible on the posedge after the request; no internal bubbles.
//  Sticky flags clear only on Init.
// TESTING
//  1 Init pulse, then 9 free clocks -> PC 0..8, then 9 with Halt=1; 5 more clocks -> PC=9, Halt=1.
//  2 At PC=3, Branch_en=1 FLAG_IN=1 Br_rel=1 Target=-2 -> PC=1.
//    At PC=3, same with FLAG_IN=0 -> PC=4.
//  3 At PC=2: Call_en Target=0x40 -> PC=0x40; 3 clocks -> 0x43; Ret_en -> PC=3, count=0.
//  4 Five nested calls with RAS_DEPTH=4 -> Ras_ovf=1; 4 rets return innermost-first.
//    5th ret -> PC+1, Ras_unf=1.
//  5 Stall=1 with Call_en=1 for 3 cycles -> PC, RAS unchanged.
//    Call_en+Ret_en same cycle, RAS empty -> Ras_unf=1, PC+1, no push.
//  6 In HALTED: Start -> PC=0, Halt=0 next edge.
//    Async Init mid-call, between clock edges -> PC=0 immediately, count=0, flags 0.

Source files
------------

// File: rtl/fetch_ctl_ras.sv
// fetch_ctl_ras - instruction-fetch program counter with return-address stack.
//
// Purpose: produces the instruction ROM address. Supports stall, absolute or
// PC-relative conditional branches, call/return through a circular RAS, a
// sticky HALTED state entered when HALT_ADDR retires, and restart via Start.
//
// Ports:
//   CLK        in   clock, all state changes on posedge
//   Init       in   asynchronous active-high reset
//   Stall      in   hold everything this cycle (RUN only)
//   Start      in   restart pulse, honoured in HALTED only
//   Branch_en  in   conditional branch request (taken when FLAG_IN=1)
//   FLAG_IN    in   branch condition
//   Br_rel     in   1: target = PC + signed Target, 0: target = Target
//   Target     in   branch/call target
//   Call_en    in   push PC+1 and jump to Target (always absolute)
//   Ret_en     in   pop RAS into PC
//   PC         out  program counter
//   Halt       out  1 while HALTED
//   Ras_ovf    out  sticky: push while RAS full
//   Ras_unf    out  sticky: pop while RAS empty
module fetch_ctl_ras #(
    parameter int PC_W      = 10,
    parameter int HALT_ADDR = 8,
    parameter int RAS_DEPTH = 4,
    parameter int REL_EN    = 1
) (
    input  logic            CLK,
    input  logic            Init,
    input  logic            Stall,
    input  logic            Start,
    input  logic            Branch_en,
    input  logic            FLAG_IN,
    input  logic            Br_rel,
    input  logic [PC_W-1:0] Target,
    input  logic            Call_en,
    input  logic            Ret_en,
    output logic [PC_W-1:0] PC,
    output logic            Halt,
    output logic            Ras_ovf,
    output logic            Ras_unf
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [PC_W-1:0]  PC_ZERO  = {PC_W{1'b0}};
    localparam logic [PC_W-1:0]  PC_ONE   = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [PC_W-1:0]  HALT_PC  = PC_W'(HALT_ADDR);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [PTR_W-1:0] PTR_ONE  = {{(PTR_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam bit               REL_ON   = (REL_EN != 0);

    typedef enum logic {S_RUN = 1'b0, S_HALTED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // sp points at the slot the next push writes; top of stack is sp-1.
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [PC_W-1:0] ras_q [RAS_DEPTH];
    logic [PC_W-1:0] ras_d [RAS_DEPTH];

    logic [PC_W-1:0] pc_inc_s;
    logic [PTR_W-1:0] top_idx_s;
    logic            taken_s;

    assign pc_inc_s  = pc_q + PC_ONE;
    assign top_idx_s = sp_q - PTR_ONE;
    assign taken_s   = Branch_en & FLAG_IN;

    // Next-state, next-PC and RAS update logic.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        cnt_d   = cnt_q;
        sp_d    = sp_q;
        ras_d   = ras_q;
        case (state_q)
            S_RUN: begin
                if (Stall) begin
                    pc_d = pc_q;
                end else if (Ret_en) begin
                    if (cnt_q != CNT_ZERO) begin
                        pc_d  = ras_q[top_idx_s];
                        sp_d  = top_idx_s;
                        cnt_d = cnt_q - CNT_ONE;
                    end else begin
                        pc_d  = pc_inc_s;
                        unf_d = 1'b1;
                    end
                end else if (Call_en) begin
                    // Circular buffer: a push when full lands on the oldest entry.
                    pc_d        = Target;
                    ras_d[sp_q] = pc_inc_s;
                    sp_d        = sp_q + PTR_ONE;
                    if (cnt_q == CNT_FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else if (taken_s) begin
                    if (Br_rel && REL_ON) begin
                        pc_d = pc_q + Target;
                    end else begin
                        pc_d = Target;
                    end
                end else if (pc_q == HALT_PC) begin
                    pc_d    = pc_inc_s;
                    state_d = S_HALTED;
                end else begin
                    pc_d = pc_inc_s;
                end
            end
            S_HALTED: begin
                if (Start) begin
                    pc_d    = PC_ZERO;
                    state_d = S_RUN;
                end else begin
                    pc_d = pc_q;
                end
            end
            default: begin
                pc_d    = PC_ZERO;
                state_d = S_RUN;
            end
        endcase
    end

    // State, PC, flag and RAS registers with asynchronous reset.
    always_ff @(posedge CLK or posedge Init) begin
        if (Init) begin
            state_q <= S_RUN;
            pc_q    <= PC_ZERO;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            cnt_q   <= CNT_ZERO;
            sp_q    <= PTR_ZERO;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= PC_ZERO;
            end
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            cnt_q   <= cnt_d;
            sp_q    <= sp_d;
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_q[i] <= ras_d[i];
            end
        end
    end

    assign PC      = pc_q;
    assign Halt    = (state_q == S_HALTED);
    assign Ras_ovf = ovf_q;
    assign Ras_unf = unf_q;

endmodule

// File: tb/tb_fetch_ctl_ras.sv
module tb_fetch_ctl_ras;

    logic       CLK = 1'b0;
    logic       Init, Stall, Start, Branch_en, FLAG_IN, Br_rel, Call_en, Ret_en;
    logic [9:0] Target;
    logic [9:0] PC;
    logic       Halt, Ras_ovf, Ras_unf;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctl_ras #(.PC_W(10), .HALT_ADDR(8), .RAS_DEPTH(4), .REL_EN(1)) dut (
        .CLK(CLK), .Init(Init), .Stall(Stall), .Start(Start),
        .Branch_en(Branch_en), .FLAG_IN(FLAG_IN), .Br_rel(Br_rel),
        .Target(Target), .Call_en(Call_en), .Ret_en(Ret_en),
        .PC(PC), .Halt(Halt), .Ras_ovf(Ras_ovf), .Ras_unf(Ras_unf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       stall, start, br, flag, rel;
        logic [9:0] tgt;
        logic       call, ret;
        logic [9:0] pc;
        logic       halt, ovf, unf;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic stall, logic start, logic br, logic flag, logic rel,
                                logic [9:0] tgt, logic call, logic ret,
                                logic [9:0] pc, logic halt, logic ovf, logic unf);
        vec_t v;
        v.stall = stall; v.start = start; v.br = br; v.flag = flag; v.rel = rel;
        v.tgt = tgt; v.call = call; v.ret = ret;
        v.pc = pc; v.halt = halt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Stall = 1'b0; Start = 1'b0; Branch_en = 1'b0; FLAG_IN = 1'b0;
        Br_rel = 1'b0; Call_en = 1'b0; Ret_en = 1'b0; Target = 10'h000;
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [9:0] pc, input logic halt,
                             input logic ovf, input logic unf);
        check({tag, " PC"}, {22'd0, PC}, {22'd0, pc});
        check({tag, " Halt"}, {31'd0, Halt}, {31'd0, halt});
        check({tag, " Ras_ovf"}, {31'd0, Ras_ovf}, {31'd0, ovf});
        check({tag, " Ras_unf"}, {31'd0, Ras_unf}, {31'd0, unf});
    endtask

    initial begin
        //                stl st br fl rl tgt      cl rt  pc       h  o  u
        tbl.push_back(mk(0, 1, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 0, 0)); // Start leaves HALTED
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h001, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h002, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h003, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 1, 1, 10'h3FE, 0, 0, 10'h001, 0, 0, 0)); // rel -2 from 3
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h002, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h003, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, 0, 1, 10'h3FE, 0, 0, 10'h004, 0, 0, 0)); // not taken
        tbl.push_back(mk(0, 0, 1, 1, 0, 10'h002, 0, 0, 10'h002, 0, 0, 0)); // absolute
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h040, 1, 0, 10'h040, 0, 0, 0)); // call, push 3
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h041, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h042, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h043, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 10'h003, 0, 0, 0)); // ret
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h100, 1, 0, 10'h100, 0, 0, 0)); // push 004
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h200, 1, 0, 10'h200, 0, 0, 0)); // push 101
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h300, 1, 0, 10'h300, 0, 0, 0)); // push 201
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h050, 1, 0, 10'h050, 0, 0, 0)); // push 301, full
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h060, 1, 0, 10'h060, 0, 1, 0)); // push 051, overflow
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 10'h051, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 10'h301, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 10'h201, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 10'h101, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 10'h102, 0, 1, 1)); // underflow
        tbl.push_back(mk(1, 0, 0, 0, 0, 10'h3FF, 1, 0, 10'h102, 0, 1, 1)); // stalled call
        tbl.push_back(mk(1, 0, 0, 0, 0, 10'h3FF, 1, 0, 10'h102, 0, 1, 1));
        tbl.push_back(mk(1, 0, 0, 0, 0, 10'h3FF, 1, 0, 10'h102, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h3FF, 1, 1, 10'h103, 0, 1, 1)); // ret wins, no push
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h104, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 1, 10'h105, 0, 1, 1)); // still empty
        tbl.push_back(mk(0, 0, 1, 1, 1, 10'h010, 1, 0, 10'h010, 0, 1, 1)); // call beats branch
        tbl.push_back(mk(0, 0, 1, 1, 0, 10'h020, 0, 1, 10'h106, 0, 1, 1)); // ret beats branch
        tbl.push_back(mk(0, 0, 1, 1, 0, 10'h3FF, 0, 0, 10'h3FF, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 1)); // wrap
        tbl.push_back(mk(0, 0, 1, 1, 1, 10'h3FE, 0, 0, 10'h3FE, 0, 1, 1)); // rel wrap below 0
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h3FF, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 10'h008, 0, 0, 10'h008, 0, 1, 1));
        tbl.push_back(mk(0, 0, 1, 1, 0, 10'h008, 0, 0, 10'h008, 0, 1, 1)); // jump at halt addr
        tbl.push_back(mk(0, 0, 0, 0, 0, 10'h000, 0, 0, 10'h009, 1, 1, 1)); // halts
        tbl.push_back(mk(1, 0, 1, 1, 0, 10'h033, 1, 1, 10'h009, 1, 1, 1)); // all ignored
        tbl.push_back(mk(0, 1, 0, 0, 0, 10'h000, 0, 0, 10'h000, 0, 1, 1)); // restart keeps flags
        tbl.push_back(mk(0, 1, 0, 0, 0, 10'h000, 0, 0, 10'h001, 0, 1, 1)); // Start ignored in RUN

        idle_inputs();
        Init = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        check_all("reset", 10'h000, 1'b0, 1'b0, 1'b0);
        Init = 1'b0;

        // Free run up to and through the halt address.
        for (int i = 1; i <= 9; i++) begin
            step();
            check($sformatf("freerun PC %0d", i), {22'd0, PC}, i);
            check($sformatf("freerun Halt %0d", i), {31'd0, Halt}, (i == 9) ? 32'd1 : 32'd0);
        end
        for (int i = 0; i < 5; i++) begin
            step();
            check_all($sformatf("halted %0d", i), 10'h009, 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            Stall = tbl[i].stall; Start = tbl[i].start; Branch_en = tbl[i].br;
            FLAG_IN = tbl[i].flag; Br_rel = tbl[i].rel; Target = tbl[i].tgt;
            Call_en = tbl[i].call; Ret_en = tbl[i].ret;
            step();
            check_all($sformatf("vec %0d", i), tbl[i].pc, tbl[i].halt, tbl[i].ovf, tbl[i].unf);
        end

        // Asynchronous Init between edges with a call in flight.
        idle_inputs();
        Call_en = 1'b1; Target = 10'h080;
        step();
        check("pre-init call PC", {22'd0, PC}, 32'h080);
        Target = 10'h090;
        #2 Init = 1'b1;
        #1;
        check_all("async init", 10'h000, 1'b0, 1'b0, 1'b0);
        #1 Init = 1'b0;
        idle_inputs();
        step();
        check_all("post-init run", 10'h001, 1'b0, 1'b0, 1'b0);
        Ret_en = 1'b1;
        step();
        check_all("post-init ret empty", 10'h002, 1'b0, 1'b0, 1'b1);
        idle_inputs();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
